// File: rtl/line_serial_tx.sv
// UART-style line serializer: start bit, 8 data bits LSB-first, stop bit, with an idle gap before FAS bytes.
// Define LINE_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module line_serial_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 4,
  parameter int FRM_CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_frame_data,
  input  logic                 i_frame_data_valid,
  input  logic                 i_frame_data_fas,
  output logic                 o_frame_data_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_busy,
  output logic [FRM_CNT_W-1:0] o_frame_cnt
);

  localparam int TMR_W      = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYC    = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef LINE_SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [2:0]           state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [FRM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 accept;
`ifdef LINE_SERIAL_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // ready_q is only ever high in IDLE, so it alone qualifies the handshake
  assign accept = i_frame_data_valid & ready_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef LINE_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = i_frame_data;
`ifdef LINE_SERIAL_TX_PARITY_EN
          par_d   = ^i_frame_data;
`endif
          tmr_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
          if (i_frame_data_fas) cnt_d = cnt_q + FRM_CNT_W'(1);
          state_d = (i_frame_data_fas && (GAP_BITS > 0)) ? S_GAP : S_START;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_START;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_START: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef LINE_SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`ifdef LINE_SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          state_d = S_STOP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so the output register lines up with it
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef LINE_SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Byte holding register carries no reset; it is only read after a fresh load
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
`ifdef LINE_SERIAL_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign o_frame_data_ready = ready_q;
  assign o_tx_serial        = tx_q;
  assign o_tx_busy          = busy_q;
  assign o_frame_cnt        = cnt_q;

endmodule

// File: doc/line_serial_tx.md
Name: line_serial_tx

Overview:
- Downstream neighbour of the mapper. Consumes framed bytes (data + FAS flag) from the line FIFO output and serializes them onto the single-wire line.
- Line format is UART-style: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Before each FAS-flagged byte, the block inserts a programmable idle gap (line held high) so the receiver can re-align on frame boundaries.
- Reports busy status and a running count of transmitted frames.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per line bit (868 = 100 MHz / 115200); legal range ≥ 2.
- GAP_BITS, 4, idle bit-times inserted before each FAS byte; 0 disables the gap.
- FRM_CNT_W, 16, width of o_frame_cnt.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_frame_data  in  8  byte from line FIFO
- i_frame_data_valid  in  1  byte valid (AXIS valid)
- i_frame_data_fas  in  1  byte is first byte of a frame (FAS)
- o_frame_data_ready  out  1  block can accept a byte (AXIS ready)
- o_tx_serial  out  1  serial line output, idle high
- o_tx_busy  out  1  high whenever state ≠ IDLE
- o_frame_cnt  out  FRM_CNT_W  number of FAS bytes accepted, wraps

Behaviour:
- Reset values: o_tx_serial=1, o_frame_data_ready=0, o_tx_busy=0, o_frame_cnt=0; state=IDLE; bit timer=0; bit index=0.
- All outputs are registered; o_tx_serial has no combinational path from inputs.
- Ready is asserted only in IDLE. It first rises in the cycle after i_rst deasserts.
- Handshake: a byte is accepted on a rising edge where valid & ready are both 1. Data and FAS are latched into a shift register. Ready drops in the next cycle. Valid without ready has no effect.
- FSM transitions:
  - IDLE → GAP on accept, if FAS=1 and GAP_BITS>0.
  - IDLE → START on any other accept.
  - GAP: line=1 for GAP_BITS*CLKS_PER_BIT cycles, then → START.
  - START: line=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, each CLKS_PER_BIT cycles, bit0 first; after bit7 → STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then → IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT). A separate gap counter sized for GAP_BITS*CLKS_PER_BIT times the gap.
- Latency: accept at edge N (non-FAS), so the start bit occupies cycles N+1..N+CLKS_PER_BIT. The stop bit ends at cycle N+10*CLKS_PER_BIT, and ready is high again at N+10*CLKS_PER_BIT+1.
- Back-to-back bytes are separated by exactly 1 extra clock cycle of line high (the IDLE accept cycle).
- FAS bytes add GAP_BITS*CLKS_PER_BIT cycles before the start bit.
- o_frame_cnt increments on the accept edge of each FAS byte. It wraps from 2^FRM_CNT_W-1 to 0.
- Data changes on i_frame_data while not ready are ignored; the latched copy is transmitted.
- Reset mid-byte: on the next edge, the FSM returns to IDLE and the line goes high immediately. The partial byte is discarded and the counter clears.
- Simultaneous i_rst and accept: reset wins; the byte is not consumed (ready is 0 during reset).

Optional Feature:
- Macro: LINE_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Byte time becomes 11*CLKS_PER_BIT; ready returns at N+11*CLKS_PER_BIT+1.
- Undefined: no PARITY state, 10-bit character as above.

Test Plan (CLKS_PER_BIT=4, GAP_BITS=2, parity off unless stated):
- Reset release → ready=0 in the release cycle, 1 the next cycle; line=1; busy=0; frame_cnt=0.
- Send 0xA5 (FAS=0) accepted at cycle N → line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles starting N+1; ready high at N+41.
- Send 0x3C with FAS=1 → line high 8 cycles after accept, then start bit; frame_cnt=1; total 48 cycles until ready.
- Stream of 3 bytes with valid held high → each accepted exactly when ready=1; 1-cycle idle between stop and next start; no byte dropped or duplicated.
- Assert i_rst during DATA bit 3 → next cycle line=1, state IDLE, busy=0; following byte transmits cleanly.
- With LINE_SERIAL_TX_PARITY_EN, send 0x07 → parity bit=1 after bit7, stop follows; ready at N+45. Preload frame_cnt to 0xFFFF and send FAS → wraps to 0.
